// File: rtl/mips16_pkg.sv
// mips16_pkg: opcodes, instruction field positions and hazard FSM encoding for the 16-bit MIPS decode stage.
package mips16_pkg;
    localparam logic [2:0] OP_RTYPE = 3'b000;
    localparam logic [2:0] OP_ADDI  = 3'b001;
    localparam logic [2:0] OP_LW    = 3'b010;
    localparam logic [2:0] OP_SW    = 3'b011;
    localparam logic [2:0] OP_BEQ   = 3'b100;
    localparam int OP_HI = 15;
    localparam int OP_LO = 13;
    localparam int RS_HI = 12;
    localparam int RS_LO = 10;
    localparam int RT_HI = 9;
    localparam int RT_LO = 7;
    localparam int RD_HI = 6;
    localparam int RD_LO = 4;
    typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, FREEZE = 2'd2} hz_state_e;
    function automatic logic uses_rt(input logic [2:0] op);
        return op == OP_RTYPE || op == OP_SW || op == OP_BEQ;
    endfunction
endpackage

// File: rtl/decode_hazard_ctrl_if.sv
// decode_hazard_ctrl_if: decode-stage control inputs and pipeline enable outputs.
interface decode_hazard_ctrl_if #(parameter int CNT_W = 16);
    logic             id_valid;
    logic [15:0]      id_instr;
    logic             id_reg_write;
    logic             id_mem_read;
    logic             id_reg_dst;
    logic             ex_branch_taken;
    logic             mem_wait;
    logic             pc_write_en;
    logic             ifid_write_en;
    logic             ifid_flush;
    logic             idex_bubble;
    logic [1:0]       hz_state;
    logic [CNT_W-1:0] stall_cycles;
    modport master (
        output id_valid, id_instr, id_reg_write, id_mem_read, id_reg_dst, ex_branch_taken, mem_wait,
        input  pc_write_en, ifid_write_en, ifid_flush, idex_bubble, hz_state, stall_cycles
    );
    modport slave (
        input  id_valid, id_instr, id_reg_write, id_mem_read, id_reg_dst, ex_branch_taken, mem_wait,
        output pc_write_en, ifid_write_en, ifid_flush, idex_bubble, hz_state, stall_cycles
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register pending-write counters for r1..r7 with two busy read ports; r0 is never busy.
module hazard_scoreboard #(
    parameter int LOAD_LAT = 1,
    parameter int ALU_LAT  = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hold,
    input  logic       issue,
    input  logic       is_load,
    input  logic [2:0] dest,
    input  logic [2:0] rs,
    input  logic [2:0] rt,
    output logic       rs_busy,
    output logic       rt_busy
);
    logic [7:0] busy;
    logic [1:0] lat;
    assign lat = is_load ? 2'(LOAD_LAT) : 2'(ALU_LAT);
    assign busy[0] = 1'b0;
    for (genvar g = 1; g < 8; g++) begin : g_ent
        logic [1:0] cnt;
        // an issue to this register wins over the per-cycle countdown
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) cnt <= '0;
            else if (!hold) cnt <= (issue && dest == 3'(g)) ? lat : cnt - {1'b0, busy[g]};
        assign busy[g] = cnt != 2'd0;
    end
    assign rs_busy = busy[rs];
    assign rt_busy = busy[rt];
endmodule

// File: rtl/decode_hazard_ctrl.sv
// decode_hazard_ctrl: decode-stage sequencer for load-use stalls, branch squash and memory-wait freeze.
module decode_hazard_ctrl
    import mips16_pkg::*;
#(
    parameter int LOAD_LAT     = 1,
    parameter int ALU_LAT      = 0,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    decode_hazard_ctrl_if.slave bus
);
    localparam int FW = $clog2(FLUSH_CYCLES + 1);
    hz_state_e state, state_n, saved, saved_n, cur;
    logic [FW-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] stall_q;
    logic [2:0] op, rs, rt, dest;
    logic rs_busy, rt_busy, hazard, squash, issue;
    logic pc_we, ifid_we, flush, bubble;
    logic unused_imm;
    assign unused_imm = ^bus.id_instr[RD_LO-1:0];
    assign op   = bus.id_instr[OP_HI:OP_LO];
    assign rs   = bus.id_instr[RS_HI:RS_LO];
    assign rt   = bus.id_instr[RT_HI:RT_LO];
    assign dest = bus.id_reg_dst ? bus.id_instr[RD_HI:RD_LO] : rt;
    // on the cycle mem_wait drops, behave as the state that was frozen
    assign cur    = state == FREEZE ? saved : state;
    assign hazard = bus.id_valid & (rs_busy | (uses_rt(op) & rt_busy));
    assign squash = bus.ex_branch_taken | (cur == FLUSH);
    assign issue  = ~bus.mem_wait & bus.id_valid & ~hazard & ~squash & bus.id_reg_write & (dest != 3'd0);
    hazard_scoreboard #(.LOAD_LAT(LOAD_LAT), .ALU_LAT(ALU_LAT)) u_sb (
        .clk     (clk),
        .rst_n   (rst_n),
        .hold    (bus.mem_wait),
        .issue   (issue),
        .is_load (bus.id_mem_read),
        .dest    (dest),
        .rs      (rs),
        .rt      (rt),
        .rs_busy (rs_busy),
        .rt_busy (rt_busy)
    );
    always_comb begin
        state_n = cur;
        saved_n = saved;
        cnt_n   = cnt;
        pc_we   = 1'b1;
        ifid_we = 1'b1;
        flush   = 1'b0;
        bubble  = 1'b0;
        if (bus.mem_wait) begin
            state_n = FREEZE;
            saved_n = cur;
            pc_we   = 1'b0;
            ifid_we = 1'b0;
        end else if (squash) begin
            flush   = 1'b1;
            bubble  = 1'b1;
            state_n = bus.ex_branch_taken ? (FLUSH_CYCLES > 1 ? FLUSH : RUN) : (cnt > FW'(1) ? FLUSH : RUN);
            cnt_n   = bus.ex_branch_taken ? FW'(FLUSH_CYCLES - 1) : (cnt > FW'(1) ? cnt - FW'(1) : '0);
        end else if (hazard) begin
            pc_we   = 1'b0;
            ifid_we = 1'b0;
            bubble  = 1'b1;
        end
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state   <= RUN;
            saved   <= RUN;
            cnt     <= '0;
            stall_q <= '0;
        end else begin
            state   <= state_n;
            saved   <= saved_n;
            cnt     <= cnt_n;
            stall_q <= (!pc_we && stall_q != '1) ? stall_q + 1'b1 : stall_q;
        end
    assign bus.pc_write_en   = pc_we;
    assign bus.ifid_write_en = ifid_we;
    assign bus.ifid_flush    = flush;
    assign bus.idex_bubble   = bubble;
    assign bus.hz_state      = state;
    assign bus.stall_cycles  = stall_q;
endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// tb_decode_hazard_ctrl: directed and random stimulus checked against a pending-latency reference model.
module tb_decode_hazard_ctrl;
    localparam int FC = 2;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    int pend [8];
    int flush_left;
    int exp_stalls;
    bit last_mw;
    int snap;
    decode_hazard_ctrl_if #(.CNT_W(16)) bus ();
    decode_hazard_ctrl #(.LOAD_LAT(1), .ALU_LAT(0), .FLUSH_CYCLES(FC), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd);
        return {op, rs, rt, rd, 4'b0000};
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 8; r++) pend[r] = 0;
        flush_left = 0;
        exp_stalls = 0;
        last_mw    = 1'b0;
    endtask

    task automatic step(input string tag, input logic v, input logic [15:0] ins, input logic rw, input logic mr,
                        input logic rd, input logic br, input logic mw);
        int op, rs, rt, dst;
        bit hz, uses;
        logic e_pc, e_ifid, e_fl, e_bub;
        logic [1:0] e_st;
        bus.id_valid = v;
        bus.id_instr = ins;
        bus.id_reg_write = rw;
        bus.id_mem_read = mr;
        bus.id_reg_dst = rd;
        bus.ex_branch_taken = br;
        bus.mem_wait = mw;
        #1;
        op   = int'(ins[15:13]);
        rs   = int'(ins[12:10]);
        rt   = int'(ins[9:7]);
        dst  = rd ? int'(ins[6:4]) : rt;
        uses = (op == 0) || (op == 3) || (op == 4);
        hz   = 1'b0;
        e_st = last_mw ? 2'd2 : (flush_left > 0 ? 2'd1 : 2'd0);
        if (mw) {e_pc, e_ifid, e_fl, e_bub} = 4'b0000;
        else if (br || flush_left > 0) {e_pc, e_ifid, e_fl, e_bub} = 4'b1111;
        else begin
            hz = v && (pend[rs] > 0 || (uses && pend[rt] > 0));
            {e_pc, e_ifid, e_fl, e_bub} = hz ? 4'b0001 : 4'b1100;
        end
        chk({tag, ".pc_write_en"}, 32'(bus.pc_write_en), 32'(e_pc));
        chk({tag, ".ifid_write_en"}, 32'(bus.ifid_write_en), 32'(e_ifid));
        chk({tag, ".ifid_flush"}, 32'(bus.ifid_flush), 32'(e_fl));
        chk({tag, ".idex_bubble"}, 32'(bus.idex_bubble), 32'(e_bub));
        chk({tag, ".hz_state"}, 32'(bus.hz_state), 32'(e_st));
        chk({tag, ".stall_cycles"}, 32'(bus.stall_cycles), 32'(exp_stalls));
        if (!mw) begin
            for (int r = 0; r < 8; r++) if (pend[r] > 0) pend[r]--;
            if (br) flush_left = FC - 1;
            else if (flush_left > 0) flush_left--;
            else if (!hz && v && rw && dst != 0) pend[dst] = mr ? 1 : 0;
        end
        if (!e_pc) exp_stalls++;
        last_mw = mw;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input string tag, input logic br, input logic mw);
        step(tag, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, br, mw);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".pc_write_en"}, 32'(bus.pc_write_en), 32'd1);
        chk({tag, ".ifid_write_en"}, 32'(bus.ifid_write_en), 32'd1);
        chk({tag, ".ifid_flush"}, 32'(bus.ifid_flush), 32'd0);
        chk({tag, ".idex_bubble"}, 32'(bus.idex_bubble), 32'd0);
        chk({tag, ".hz_state"}, 32'(bus.hz_state), 32'd0);
        chk({tag, ".stall_cycles"}, 32'(bus.stall_cycles), 32'd0);
    endtask

    initial begin
        logic [2:0] op;
        logic [15:0] lw3, add4, lw5, lw0, use0;
        bus.id_valid = 1'b0;
        bus.id_instr = '0;
        bus.id_reg_write = 1'b0;
        bus.id_mem_read = 1'b0;
        bus.id_reg_dst = 1'b0;
        bus.ex_branch_taken = 1'b0;
        bus.mem_wait = 1'b0;
        model_reset();
        lw3  = mk(3'b010, 3'd1, 3'd3, 3'd0);
        add4 = mk(3'b000, 3'd3, 3'd1, 3'd4);
        lw5  = mk(3'b010, 3'd2, 3'd5, 3'd0);
        lw0  = mk(3'b010, 3'd1, 3'd0, 3'd0);
        use0 = mk(3'b000, 3'd0, 3'd2, 3'd6);
        // 1: reset
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        // 2: load-use stall of one cycle
        step("t2_lw", 1'b1, lw3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step("t2_stall", 1'b1, add4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t2_stall_seen", 32'(exp_stalls), 32'd1);
        step("t2_issue", 1'b1, add4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t2_stall_cycles", 32'(bus.stall_cycles), 32'd1);
        // 3: ALU result forwarded, no stall
        step("t3_add", 1'b1, mk(3'b000, 3'd1, 3'd1, 3'd2), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step("t3_sub", 1'b1, mk(3'b000, 3'd2, 3'd2, 3'd7), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t3_no_stall", 32'(bus.stall_cycles), 32'd1);
        // 4: taken branch squashes LW r5; a later use of r5 must not stall
        step("t4_br", 1'b1, lw5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step("t4_flush", 1'b1, lw5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step("t4_use5", 1'b1, mk(3'b000, 3'd5, 3'd5, 3'd6), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t4_no_stall", 32'(bus.stall_cycles), 32'd1);
        // 5: freeze during a load-use stall
        snap = int'(bus.stall_cycles);
        step("t5_lw", 1'b1, lw3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step("t5_freeze", 1'b1, add4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step("t5_release", 1'b1, add4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step("t5_issue", 1'b1, add4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t5_stall_delta", 32'(int'(bus.stall_cycles) - snap), 32'd4);
        // 7: r0 is never tracked
        step("t7_lw0", 1'b1, lw0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step("t7_use0", 1'b1, use0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        // 6: async reset in the middle of a flush
        step("t6_br", 1'b1, lw3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        bus.ex_branch_taken = 1'b0;
        #2;
        chk("t6_in_flush", 32'(bus.hz_state), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step("t6_after_lw3", 1'b1, add4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        // random traffic
        for (int i = 0; i < 400; i++) begin
            logic rw, mr, rd;
            op = 3'($urandom_range(0, 4));
            rw = (op == 3'b000) || (op == 3'b001) || (op == 3'b010);
            mr = op == 3'b010;
            rd = op == 3'b000;
            step("rand", 1'($urandom_range(0, 5) != 0),
                 mk(op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))),
                 rw, mr, rd, 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 7) == 0));
        end
        idle("drain", 1'b0, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
